// File: rtl/rle_enc_pkg.sv
// rtl/rle_enc_pkg.sv - shared widths, token layout and FSM states for the run-length encoder
package rle_enc_pkg;

   localparam int RLE_SYM_W = 8;
   localparam int RLE_CNT_W = 4;

   // One emitted token: symbol, run length (1..2**CNT_W-1), frame-closing flag
   typedef struct packed {
      logic [RLE_SYM_W-1:0] sym;
      logic [RLE_CNT_W-1:0] len;
      logic                 last;
   } rle_tok_t;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_RUN   = 2'd1,
      ST_CLOSE = 2'd2
   } rle_state_t;

endpackage

// File: rtl/rle_enc_oreg.sv
// rtl/rle_enc_oreg.sv - one-entry valid/ready output register (load, drain, hold)
module rle_enc_oreg
   import rle_enc_pkg::*;
#(
   parameter int DATA_W = RLE_SYM_W + RLE_CNT_W + 1
) (
   input  logic              clk,
   input  logic              arst,
   input  logic              i_load,
   input  logic [DATA_W-1:0] i_data,
   input  logic              i_rdy,
   output logic              o_vld,
   output logic [DATA_W-1:0] o_data
);

   logic              r_vld;
   logic [DATA_W-1:0] r_data;

   // Load wins over drain so a token can replace the one leaving this cycle;
   // the caller only loads when the slot is free, so nothing is overwritten.
   always_ff @(posedge clk or posedge arst) begin
      if (arst) begin
         r_vld  <= 1'b0;
         r_data <= '0;
      end else if (i_load) begin
         r_vld  <= 1'b1;
         r_data <= i_data;
      end else if (i_rdy) begin
         r_vld  <= 1'b0;
      end
   end

   assign o_vld  = r_vld;
   assign o_data = r_data;

endmodule

// File: rtl/rle_enc.sv
// rtl/rle_enc.sv - run-length encoder top; RLE_ENC_STATS_EN adds token/symbol counters
module rle_enc
   import rle_enc_pkg::*;
#(
   parameter int SYM_W = RLE_SYM_W,
   parameter int CNT_W = RLE_CNT_W
) (
   input  logic             clk,
   input  logic             arst,
   input  logic             in_vld,
   input  logic [SYM_W-1:0] in_sym,
   input  logic             in_last,
   output logic             in_rdy,
   output logic             out_vld,
   output logic [SYM_W-1:0] out_sym,
   output logic [CNT_W-1:0] out_len,
   output logic             out_last,
   input  logic             out_rdy
`ifdef RLE_ENC_STATS_EN
   ,
   output logic [31:0]      stat_tok,
   output logic [31:0]      stat_sym
`endif
);

   localparam int               TOK_W   = SYM_W + CNT_W + 1;
   localparam logic [CNT_W-1:0] MAX_RUN = '1;
   localparam logic [CNT_W-1:0] ONE     = CNT_W'(1);

   rle_state_t       r_state;
   logic [SYM_W-1:0] r_sym;
   logic [CNT_W-1:0] r_cnt;
   logic             r_last;

   logic             w_slot_free;
   logic             w_match;
   logic             w_sat;
   logic             w_extend;
   logic             w_in_rdy;
   logic             w_acc;
   logic             w_load;
   logic [TOK_W-1:0] w_load_data;
   logic [TOK_W-1:0] w_out_data;

   assign w_slot_free = !out_vld | out_rdy;
   assign w_match     = (r_state == ST_RUN) && (in_sym == r_sym);
   assign w_sat       = (r_cnt == MAX_RUN);
   assign w_extend    = w_match & !w_sat;

   // Ready: extending a run never needs the output slot, closing one does;
   // held low while reset is asserted.
   always_comb begin
      w_in_rdy = 1'b0;
      if (!arst) begin
         case (r_state)
            ST_IDLE:  w_in_rdy = 1'b1;
            ST_RUN:   w_in_rdy = w_extend | w_slot_free;
            default:  w_in_rdy = 1'b0;
         endcase
      end
   end

   assign in_rdy = w_in_rdy;
   assign w_acc  = in_vld & w_in_rdy;

   // A run leaves either when a non-extending symbol arrives or when the
   // frame is closing and the slot has room.
   assign w_load      = ((r_state == ST_RUN) && w_acc && !w_extend) ||
                        ((r_state == ST_CLOSE) && w_slot_free);
   assign w_load_data = {r_sym, r_cnt, r_last};

   // Run-register FSM: open, extend, roll over or close the current run.
   always_ff @(posedge clk or posedge arst) begin
      if (arst) begin
         r_state <= ST_IDLE;
         r_sym   <= '0;
         r_cnt   <= '0;
         r_last  <= 1'b0;
      end else begin
         case (r_state)
            ST_IDLE: begin
               if (w_acc) begin
                  r_sym   <= in_sym;
                  r_cnt   <= ONE;
                  r_last  <= in_last;
                  r_state <= in_last ? ST_CLOSE : ST_RUN;
               end
            end
            ST_RUN: begin
               if (w_acc) begin
                  if (w_extend) begin
                     r_cnt <= r_cnt + ONE;
                  end else begin
                     r_sym <= in_sym;
                     r_cnt <= ONE;
                  end
                  r_last <= in_last;
                  if (in_last) r_state <= ST_CLOSE;
               end
            end
            ST_CLOSE: begin
               if (w_slot_free) begin
                  r_cnt   <= '0;
                  r_last  <= 1'b0;
                  r_state <= ST_IDLE;
               end
            end
            default: r_state <= ST_IDLE;
         endcase
      end
   end

   rle_enc_oreg #(.DATA_W(TOK_W)) u_oreg (
      .clk    (clk),
      .arst   (arst),
      .i_load (w_load),
      .i_data (w_load_data),
      .i_rdy  (out_rdy),
      .o_vld  (out_vld),
      .o_data (w_out_data)
   );

   assign {out_sym, out_len, out_last} = w_out_data;

`ifdef RLE_ENC_STATS_EN
   logic [31:0] r_stat_tok;
   logic [31:0] r_stat_sym;

   // Free-running wrap-around handshake counters.
   always_ff @(posedge clk or posedge arst) begin
      if (arst) begin
         r_stat_tok <= '0;
         r_stat_sym <= '0;
      end else begin
         if (out_vld && out_rdy) r_stat_tok <= r_stat_tok + 32'd1;
         if (w_acc)              r_stat_sym <= r_stat_sym + 32'd1;
      end
   end

   assign stat_tok = r_stat_tok;
   assign stat_sym = r_stat_sym;
`endif

endmodule

// File: tb/tb_rle_enc.sv
// tb/tb_rle_enc.sv - directed self-checking bench for rle_enc (optionally RLE_ENC_STATS_EN)
module tb_rle_enc;
   import rle_enc_pkg::*;

   logic       clk;
   logic       arst;
   logic       in_vld;
   logic [7:0] in_sym;
   logic       in_last;
   logic       in_rdy;
   logic       out_vld;
   logic [7:0] out_sym;
   logic [3:0] out_len;
   logic       out_last;
   logic       out_rdy;
`ifdef RLE_ENC_STATS_EN
   logic [31:0] stat_tok;
   logic [31:0] stat_sym;
`endif

   int n_checks = 0;
   int n_fail   = 0;

   rle_tok_t got_q[$];
   rle_tok_t exp_q[$];
   rle_tok_t snap;

   rle_enc u_dut (
      .clk      (clk),
      .arst     (arst),
      .in_vld   (in_vld),
      .in_sym   (in_sym),
      .in_last  (in_last),
      .in_rdy   (in_rdy),
      .out_vld  (out_vld),
      .out_sym  (out_sym),
      .out_len  (out_len),
      .out_last (out_last),
      .out_rdy  (out_rdy)
`ifdef RLE_ENC_STATS_EN
      ,
      .stat_tok (stat_tok),
      .stat_sym (stat_sym)
`endif
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Capture every output handshake mid-cycle; inputs only move just after posedge.
   always @(negedge clk) begin
      if (out_vld && out_rdy) got_q.push_back(rle_tok_t'({out_sym, out_len, out_last}));
   end

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
      end
   endtask

   task automatic idle(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   // Present one symbol and hold it until accepted (bounded wait).
   task automatic send(input logic [7:0] s, input logic l);
      int n;
      n = 0;
      in_vld  = 1'b1;
      in_sym  = s;
      in_last = l;
      @(negedge clk);
      while (!in_rdy && n < 100) begin
         @(negedge clk);
         n++;
      end
      if (n >= 100) chk("send_accept", 64'(in_rdy), 64'd1);
      @(posedge clk);
      #1;
      in_vld  = 1'b0;
      in_last = 1'b0;
   endtask

   task automatic exp_tok(input logic [7:0] s, input logic [3:0] len, input logic l);
      exp_q.push_back(rle_tok_t'({s, len, l}));
   endtask

   task automatic compare_toks(input string tag);
      chk({tag, "_count"}, 64'(got_q.size()), 64'(exp_q.size()));
      for (int i = 0; i < exp_q.size() && i < got_q.size(); i++)
         chk($sformatf("%s_tok%0d", tag, i), 64'(got_q[i]), 64'(exp_q[i]));
      got_q.delete();
      exp_q.delete();
   endtask

   initial begin
      arst    = 1'b1;
      in_vld  = 1'b0;
      in_sym  = 8'h00;
      in_last = 1'b0;
      out_rdy = 1'b1;

      // Reset state
      repeat (3) @(posedge clk);
      @(negedge clk);
      chk("rst_in_rdy",   64'(in_rdy),   64'd0);
      chk("rst_out_vld",  64'(out_vld),  64'd0);
      chk("rst_out_sym",  64'(out_sym),  64'd0);
      chk("rst_out_len",  64'(out_len),  64'd0);
      chk("rst_out_last", 64'(out_last), 64'd0);
      @(posedge clk);
      #1;
      arst = 1'b0;
      @(negedge clk);
      chk("post_rst_in_rdy", 64'(in_rdy), 64'd1);
      idle(1);

      // 1: A,A,A,B(last)
      send(8'hA1, 1'b0);
      send(8'hA1, 1'b0);
      send(8'hA1, 1'b0);
      send(8'hB2, 1'b1);
      idle(4);
      exp_tok(8'hA1, 4'd3, 1'b0);
      exp_tok(8'hB2, 4'd1, 1'b1);
      compare_toks("t1");

      // 2: 17 x 0x5A, saturation at 15
      for (int i = 0; i < 17; i++) send(8'h5A, i == 16);
      idle(4);
      exp_tok(8'h5A, 4'd15, 1'b0);
      exp_tok(8'h5A, 4'd2, 1'b1);
      compare_toks("t2");

      // 3: single symbol with last, FSM returns to IDLE
      send(8'h00, 1'b1);
      idle(4);
      exp_tok(8'h00, 4'd1, 1'b1);
      compare_toks("t3");
      @(negedge clk);
      chk("t3_idle_rdy", 64'(in_rdy), 64'd1);
      idle(1);

      // 4: backpressure for 10 cycles while streaming A,B,C
      out_rdy = 1'b0;
      send(8'h0A, 1'b0);
      send(8'h0B, 1'b0);
      fork
         send(8'h0C, 1'b1);
         begin
            @(negedge clk);
            snap = rle_tok_t'({out_sym, out_len, out_last});
            repeat (9) @(negedge clk);
            chk("t4_stall_in_rdy",  64'(in_rdy),  64'd0);
            chk("t4_stall_out_vld", 64'(out_vld), 64'd1);
            chk("t4_hold_stable",   64'(rle_tok_t'({out_sym, out_len, out_last})), 64'(snap));
            chk("t4_hold_value",    64'(rle_tok_t'({out_sym, out_len, out_last})),
                64'(rle_tok_t'({8'h0A, 4'd1, 1'b0})));
            @(posedge clk);
            #1;
            out_rdy = 1'b1;
         end
      join
      idle(5);
      exp_tok(8'h0A, 4'd1, 1'b0);
      exp_tok(8'h0B, 4'd1, 1'b0);
      exp_tok(8'h0C, 4'd1, 1'b1);
      compare_toks("t4");

      // 5: two frames of A,A(last) are never merged
      send(8'hAA, 1'b0);
      send(8'hAA, 1'b1);
      send(8'hAA, 1'b0);
      send(8'hAA, 1'b1);
      idle(4);
      exp_tok(8'hAA, 4'd2, 1'b1);
      exp_tok(8'hAA, 4'd2, 1'b1);
      compare_toks("t5");

      // 6: reset mid-run at count 7 discards the run
      for (int i = 0; i < 7; i++) send(8'h77, 1'b0);
      arst = 1'b1;
      @(negedge clk);
      chk("t6_rst_out_vld", 64'(out_vld), 64'd0);
      chk("t6_rst_in_rdy",  64'(in_rdy),  64'd0);
`ifdef RLE_ENC_STATS_EN
      chk("t6_stat_tok_clr", 64'(stat_tok), 64'd0);
      chk("t6_stat_sym_clr", 64'(stat_sym), 64'd0);
`endif
      @(posedge clk);
      #1;
      arst = 1'b0;
      idle(2);
      chk("t6_no_partial", 64'(got_q.size()), 64'd0);
      send(8'h77, 1'b0);
      send(8'h77, 1'b1);
      idle(4);
      exp_tok(8'h77, 4'd2, 1'b1);
      compare_toks("t6");
`ifdef RLE_ENC_STATS_EN
      chk("t6_stat_tok", 64'(stat_tok), 64'd1);
      chk("t6_stat_sym", 64'(stat_sym), 64'd2);
`endif

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule
